// File: rtl/load_store_unit.sv
`default_nettype none
// ==========================================================================
// load_store_unit: handshaked load/store engine, sub-word stores as RMW. Rev 1.0
// ==========================================================================
module load_store_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [DATA_W-1:0] rdata,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  input  logic [DATA_W-1:0] dmemload,
  input  logic              dhit
);
  localparam int          BYTES   = DATA_W / 8;
  localparam int          OFF_W   = $clog2(BYTES);
  localparam logic [31:0] BYTES_U = 32'(BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] dmemstore_q, dmemstore_d;

  logic [31:0]       req_bytes;
  logic              req_bad;
  logic              req_full;
  logic [OFF_W+2:0]  lane_sh;
  logic [31:0]       lane_bits;
  logic [DATA_W-1:0] field_mask;
  logic [DATA_W-1:0] shifted;
  logic              sign_bit;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] store_merged;

  assign req_bytes = 32'd1 << size;
  assign req_bad   = (req_bytes > BYTES_U) ||
                     ((32'(addr[OFF_W-1:0]) & (req_bytes - 32'd1)) != 32'd0);
  assign req_full  = (req_bytes == BYTES_U);

  // A full-width field shifts the 1 out entirely, so the mask wraps to all ones
  assign lane_sh    = {addr_q[OFF_W-1:0], 3'b000};
  assign lane_bits  = 32'd8 << size_q;
  assign field_mask = (DATA_W'(1) << lane_bits) - DATA_W'(1);

  assign shifted   = dmemload >> lane_sh;
  assign sign_bit  = |(shifted & field_mask & ~(field_mask >> 1));
  assign load_ext  = (shifted & field_mask) | ({DATA_W{sext_q & sign_bit}} & ~field_mask);

  assign lane_mask    = field_mask << lane_sh;
  assign store_merged = (dmemload & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    size_d      = size_q;
    sext_d      = sext_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    rdata_d     = rdata_q;
    dmemstore_d = dmemstore_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          wr_d    = wr;
          size_d  = size;
          sext_d  = sext;
          wdata_d = wdata;
          if (req_bad) begin
            state_d = FAULT;
          end else if (wr && req_full) begin
            state_d     = WRITE;
            dmemstore_d = wdata;
          end else begin
            state_d = READ;
          end
        end
      end
      FAULT: begin
        state_d = IDLE;
        done_d  = 1'b1;
        fault_d = 1'b1;
      end
      READ: begin
        if (dhit) begin
          if (wr_q) begin
            state_d     = WRITE;
            dmemstore_d = store_merged;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            rdata_d = load_ext;
          end
        end
      end
      WRITE: begin
        if (dhit) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      size_q      <= 2'd0;
      sext_q      <= 1'b0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= '0;
      dmemstore_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
      dmemstore_q <= dmemstore_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign fault     = fault_q;
  assign rdata     = rdata_q;
  assign dmemREN   = (state_q == READ);
  assign dmemWEN   = (state_q == WRITE);
  assign dmemaddr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign dmemstore = dmemstore_q;

endmodule
`default_nettype wire
